// File: rtl/sram_write_arbiter_if.sv
// Bundles the four write requesters and the two registered SRAM write ports.
// The arbiter uses the slave view; the requester/SRAM side uses the master view.
interface sram_write_arbiter_if;
    logic [3:0]   Req_In;
    logic [31:0]  Addr_In;
    logic [127:0] Data_In;
    logic [3:0]   Grant_Out;
    logic [31:0]  Port_W_A_Data_Out;
    logic [7:0]   Port_W_A_Address_Out;
    logic         Port_W_A_Write_Enable_Out;
    logic [31:0]  Port_W_B_Data_Out;
    logic [7:0]   Port_W_B_Address_Out;
    logic         Port_W_B_Write_Enable_Out;
    logic [1:0]   Rr_Pointer_Out;

    modport slave (
        input  Req_In, Addr_In, Data_In,
        output Grant_Out,
        output Port_W_A_Data_Out, Port_W_A_Address_Out, Port_W_A_Write_Enable_Out,
        output Port_W_B_Data_Out, Port_W_B_Address_Out, Port_W_B_Write_Enable_Out,
        output Rr_Pointer_Out
    );

    modport master (
        output Req_In, Addr_In, Data_In,
        input  Grant_Out,
        input  Port_W_A_Data_Out, Port_W_A_Address_Out, Port_W_A_Write_Enable_Out,
        input  Port_W_B_Data_Out, Port_W_B_Address_Out, Port_W_B_Write_Enable_Out,
        input  Rr_Pointer_Out
    );
endinterface

// File: rtl/sram_write_arbiter.sv
// Round-robin arbiter granting up to two of four write requesters onto SRAM ports A and B.
// Define WRITE_ADDRESS_COLLISION_CHECK_EN to stop port B from taking port A's address.
module sram_write_arbiter (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    sram_write_arbiter_if.slave   bus
);

    logic [7:0]  reqAddr [4];
    logic [31:0] reqData [4];

    logic [1:0]  rrPtr_q, rrPtr_d;
    logic        weA_q, weB_q;
    logic [7:0]  addrA_q, addrB_q;
    logic [31:0] dataA_q, dataB_q;

    logic [3:0]  grant;
    logic        aValid, bValid;
    logic [1:0]  aIdx, bIdx;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            reqAddr[i] = bus.Addr_In[8*i +: 8];
            reqData[i] = bus.Data_In[32*i +: 32];
        end
    end

    // Walk the requesters starting at the pointer; first hit takes A, next eligible hit takes B.
    always_comb begin
        logic [1:0] idx;
        logic       bBlocked;
        grant    = '0;
        aValid   = 1'b0;
        bValid   = 1'b0;
        aIdx     = '0;
        bIdx     = '0;
        idx      = '0;
        bBlocked = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = rrPtr_q + 2'(k);
`ifdef WRITE_ADDRESS_COLLISION_CHECK_EN
            bBlocked = (reqAddr[idx] == reqAddr[aIdx]);
`else
            bBlocked = 1'b0;
`endif
            if (bus.Req_In[idx]) begin
                if (!aValid) begin
                    aValid     = 1'b1;
                    aIdx       = idx;
                    grant[idx] = 1'b1;
                end else if (!bValid && !bBlocked) begin
                    bValid     = 1'b1;
                    bIdx       = idx;
                    grant[idx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rrPtr_d = rrPtr_q;
        if (aValid) begin
            rrPtr_d = (bValid ? bIdx : aIdx) + 2'd1;
        end
    end

    // A port without a grant drops its enable but keeps its last address and data.
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            rrPtr_q <= '0;
            weA_q   <= 1'b0;
            weB_q   <= 1'b0;
            addrA_q <= '0;
            addrB_q <= '0;
            dataA_q <= '0;
            dataB_q <= '0;
        end else begin
            rrPtr_q <= rrPtr_d;
            weA_q   <= aValid;
            weB_q   <= bValid;
            if (aValid) begin
                addrA_q <= reqAddr[aIdx];
                dataA_q <= reqData[aIdx];
            end
            if (bValid) begin
                addrB_q <= reqAddr[bIdx];
                dataB_q <= reqData[bIdx];
            end
        end
    end

    assign bus.Grant_Out                 = Reset_In ? 4'b0000 : grant;
    assign bus.Port_W_A_Data_Out         = dataA_q;
    assign bus.Port_W_A_Address_Out      = addrA_q;
    assign bus.Port_W_A_Write_Enable_Out = weA_q;
    assign bus.Port_W_B_Data_Out         = dataB_q;
    assign bus.Port_W_B_Address_Out      = addrB_q;
    assign bus.Port_W_B_Write_Enable_Out = weB_q;
    assign bus.Rr_Pointer_Out            = rrPtr_q;

endmodule

// File: tb/tb_sram_write_arbiter.sv
// Self-checking bench for sram_write_arbiter: directed scenarios then randomized held requests
// compared against a queue-based round-robin model.
module tb_sram_write_arbiter;

    logic clock;
    logic Reset_In;
    sram_write_arbiter_if bus();

    sram_write_arbiter dut (
        .Clk_In   (clock),
        .Reset_In (Reset_In),
        .bus      (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int passCount  = 0;
    int checkCount = 0;

    logic [1:0]  mPtr;
    logic        mWeA, mWeB;
    logic [7:0]  mAddrA, mAddrB;
    logic [31:0] mDataA, mDataB;
    logic [3:0]  obsGrant;
    logic [3:0]  modelGrant;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic modelReset();
        mPtr = 0; mWeA = 0; mWeB = 0;
        mAddrA = 0; mAddrB = 0; mDataA = 0; mDataB = 0;
    endtask

    // Reference: list requesters in round-robin order, A takes the head, B the next acceptable one.
    task automatic modelArbitrate(input logic [3:0] req, input logic [31:0] addr,
                                  output logic [3:0] g, output bit aV, output int aI,
                                  output bit bV, output int bI);
        int order[$];
        g = 0; aV = 0; bV = 0; aI = 0; bI = 0;
        for (int k = 0; k < 4; k++) begin
            int n;
            n = (int'(mPtr) + k) % 4;
            if (req[n]) order.push_back(n);
        end
        if (order.size() > 0) begin
            aI = order.pop_front();
            aV = 1;
            g[aI] = 1'b1;
        end
        while (aV && !bV && order.size() > 0) begin
            int c;
            c = order.pop_front();
`ifdef WRITE_ADDRESS_COLLISION_CHECK_EN
            if (addr[8*c +: 8] == addr[8*aI +: 8]) continue;
`endif
            bI = c;
            bV = 1;
            g[c] = 1'b1;
        end
    endtask

    task automatic runCycle();
        logic [3:0] g;
        bit aV, bV;
        int aI, bI;
        @(negedge clock);
        modelArbitrate(bus.Req_In, bus.Addr_In, g, aV, aI, bV, bI);
        obsGrant   = bus.Grant_Out;
        modelGrant = g;
        checkOutput("grant", obsGrant, g);
        @(posedge clock);
        #1;
        mWeA = aV;
        mWeB = bV;
        if (aV) begin mAddrA = bus.Addr_In[8*aI +: 8]; mDataA = bus.Data_In[32*aI +: 32]; end
        if (bV) begin mAddrB = bus.Addr_In[8*bI +: 8]; mDataB = bus.Data_In[32*bI +: 32]; end
        if (aV) mPtr = 2'((bV ? bI : aI) + 1);
        checkOutput("weA",   bus.Port_W_A_Write_Enable_Out, mWeA);
        checkOutput("addrA", bus.Port_W_A_Address_Out, mAddrA);
        checkOutput("dataA", bus.Port_W_A_Data_Out, mDataA);
        checkOutput("weB",   bus.Port_W_B_Write_Enable_Out, mWeB);
        checkOutput("addrB", bus.Port_W_B_Address_Out, mAddrB);
        checkOutput("dataB", bus.Port_W_B_Data_Out, mDataB);
        checkOutput("ptr",   bus.Rr_Pointer_Out, mPtr);
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic [31:0] addr, input logic [127:0] data);
        bus.Req_In  = req;
        bus.Addr_In = addr;
        bus.Data_In = data;
        runCycle();
    endtask

    logic        active  [4];
    logic [7:0]  pAddr   [4];
    logic [31:0] pData   [4];
    int          waitCnt [4];

    initial begin
        Reset_In    = 1'b1;
        bus.Req_In  = 4'b1111;
        bus.Addr_In = 32'h0;
        bus.Data_In = 128'h0;
        modelReset();
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_grant", bus.Grant_Out, 0);
        checkOutput("rst_weA",   bus.Port_W_A_Write_Enable_Out, 0);
        checkOutput("rst_weB",   bus.Port_W_B_Write_Enable_Out, 0);
        checkOutput("rst_ptr",   bus.Rr_Pointer_Out, 0);
        checkOutput("rst_addrA", bus.Port_W_A_Address_Out, 0);
        checkOutput("rst_dataB", bus.Port_W_B_Data_Out, 0);
        Reset_In   = 1'b0;
        bus.Req_In = 4'b0000;

        applyStimulus(4'b0001, 32'h0000_0010, {96'h0, 32'hDEADBEEF});
        checkOutput("single_grant", obsGrant, 4'b0001);
        checkOutput("single_weA",   bus.Port_W_A_Write_Enable_Out, 1);
        checkOutput("single_addrA", bus.Port_W_A_Address_Out, 8'h10);
        checkOutput("single_dataA", bus.Port_W_A_Data_Out, 32'hDEADBEEF);
        checkOutput("single_weB",   bus.Port_W_B_Write_Enable_Out, 0);
        checkOutput("single_ptr",   bus.Rr_Pointer_Out, 1);

        applyStimulus(4'b1000, 32'h4433_2211, 128'h0);
        checkOutput("to_zero_ptr", bus.Rr_Pointer_Out, 0);
        applyStimulus(4'b1111, 32'h4433_2211, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
        checkOutput("all_c1_grant", obsGrant, 4'b0011);
        checkOutput("all_c1_ptr",   bus.Rr_Pointer_Out, 2);
        applyStimulus(4'b1100, 32'h4433_2211, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
        checkOutput("all_c2_grant", obsGrant, 4'b1100);
        checkOutput("all_c2_dataB", bus.Port_W_B_Data_Out, 32'hD3);
        checkOutput("all_c2_ptr",   bus.Rr_Pointer_Out, 0);

        applyStimulus(4'b0100, 32'h4433_2211, 128'h0);
        checkOutput("to_three_ptr", bus.Rr_Pointer_Out, 3);
        applyStimulus(4'b1001, 32'h4433_2211, {32'hC3, 32'h0, 32'h0, 32'hC0});
        checkOutput("wrap_grant", obsGrant, 4'b1001);
        checkOutput("wrap_addrA", bus.Port_W_A_Address_Out, 8'h44);
        checkOutput("wrap_addrB", bus.Port_W_B_Address_Out, 8'h11);
        checkOutput("wrap_ptr",   bus.Rr_Pointer_Out, 1);

        applyStimulus(4'b1000, 32'h0, 128'h0);
        applyStimulus(4'b0011, 32'h0000_5555, {64'h0, 32'hB1, 32'hB0});
`ifdef WRITE_ADDRESS_COLLISION_CHECK_EN
        checkOutput("coll_c1_grant", obsGrant, 4'b0001);
        checkOutput("coll_c1_weB",   bus.Port_W_B_Write_Enable_Out, 0);
        checkOutput("coll_c1_ptr",   bus.Rr_Pointer_Out, 1);
        applyStimulus(4'b0011, 32'h0000_5555, {64'h0, 32'hB1, 32'hB0});
        checkOutput("coll_c2_grant", obsGrant, 4'b0010);
        checkOutput("coll_c2_dataA", bus.Port_W_A_Data_Out, 32'hB1);
`else
        checkOutput("eq_addr_grant", obsGrant, 4'b0011);
        checkOutput("eq_addr_weB",   bus.Port_W_B_Write_Enable_Out, 1);
`endif

        applyStimulus(4'b0001, 32'h0000_0077, {96'h0, 32'hA5A5A5A5});
        checkOutput("pre_rst_weA", bus.Port_W_A_Write_Enable_Out, 1);
        bus.Req_In = 4'b1111;
        #2;
        Reset_In = 1'b1;
        #1;
        checkOutput("async_rst_weA",   bus.Port_W_A_Write_Enable_Out, 0);
        checkOutput("async_rst_weB",   bus.Port_W_B_Write_Enable_Out, 0);
        checkOutput("async_rst_grant", bus.Grant_Out, 0);
        modelReset();
        @(posedge clock);
        #1;
        Reset_In   = 1'b0;
        bus.Req_In = 4'b0000;
        checkOutput("post_rst_ptr",   bus.Rr_Pointer_Out, 0);
        checkOutput("post_rst_addrA", bus.Port_W_A_Address_Out, 0);
        checkOutput("post_rst_dataA", bus.Port_W_A_Data_Out, 0);
        checkOutput("post_rst_addrB", bus.Port_W_B_Address_Out, 0);
        checkOutput("post_rst_dataB", bus.Port_W_B_Data_Out, 0);

        for (int i = 0; i < 4; i++) begin
            active[i] = 0; pAddr[i] = 0; pData[i] = 0; waitCnt[i] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [3:0]   req;
            logic [31:0]  addr;
            logic [127:0] data;
            for (int i = 0; i < 4; i++) begin
                if (!active[i] && $urandom_range(0, 1) == 1) begin
                    active[i]  = 1;
                    pAddr[i]   = 8'($urandom_range(0, 3));
                    pData[i]   = $urandom;
                    waitCnt[i] = 0;
                end
                req[i]          = active[i];
                addr[8*i +: 8]  = pAddr[i];
                data[32*i +: 32] = pData[i];
            end
            applyStimulus(req, addr, data);
            for (int i = 0; i < 4; i++) begin
                if (active[i]) begin
                    if (modelGrant[i]) begin
`ifndef WRITE_ADDRESS_COLLISION_CHECK_EN
                        checkOutput("starvation", (waitCnt[i] <= 1) ? 32'd1 : 32'd0, 32'd1);
`endif
                        active[i] = 0;
                    end else begin
                        waitCnt[i]++;
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
